refill_arbiter: RTL and testbench

- Shares the single external memory port between I-cache refill and D-cache refill/writeback.
- Sequences each request as a fixed-length line burst.
- Returns per-beat read data to the owning cache.
- Emits the one-cycle f_arrival / m_arrival completion pulses consumed by the pipeline hazard/stall logic.

---
 rtl/refill_pkg.sv | 19 +
 rtl/refill_beat_ctr.sv | 37 +++
 rtl/refill_arbiter.sv | 166 ++++++++++++++++
 tb/tb_refill_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// Shared types for the refill arbiter: FSM states, burst owner and default line geometry.
package refill_pkg;

    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IBURST = 2'd1,
        DBURST = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/refill_beat_ctr.sv
// Loadable wrapping beat counter; o_last flags the final beat of a line regardless of start word.
module refill_beat_ctr
    import refill_pkg::*;
#(
    parameter int WORDS = LINE_WORDS,
    parameter int W     = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_start,
    input  logic         i_inc,
    output logic [W-1:0] o_idx,
    output logic         o_last
);

    logic [W-1:0] r_idx;
    logic [W-1:0] r_cnt;

    // Word index wraps naturally (power-of-two line); r_cnt counts beats issued.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx <= {W{1'b0}};
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_idx <= i_start;
            r_cnt <= {W{1'b0}};
        end else if (i_inc) begin
            r_idx <= r_idx + W'(1);
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_cnt == W'(WORDS - 1));

endmodule

// File: rtl/refill_arbiter.sv
// Memory-port arbiter for I/D cache line bursts with fixed D priority.
// Optional critical-word-first read bursts: define REFILL_ARBITER_CWF_EN.
module refill_arbiter
    import refill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] i_idx,
    output logic [DATA_W-1:0]             i_rdata,
    output logic                          f_arrival,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] d_idx,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          m_arrival
);

    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam int                BYTE_W   = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);

    state_e            r_state;
    owner_e            r_owner;
    logic [ADDR_W-1:0] r_base;
    logic              r_we;

    state_e            w_next;
    logic              w_grant;
    logic              w_burst;
    logic              w_ack;
    logic              w_last;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [IDX_W-1:0]  w_start;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_beat_addr;

    assign w_grant     = (r_state == IDLE) && (d_req || i_req);
    assign w_burst     = (r_state == IBURST) || (r_state == DBURST);
    assign w_ack       = w_burst && mem_ack;
    assign w_sel_addr  = d_req ? d_addr : i_addr;
    assign w_beat_addr = r_base | (ADDR_W'(w_idx) << BYTE_W);

    // Starting word of the burst being granted this cycle.
    always_comb begin
        w_start = {IDX_W{1'b0}};
`ifdef REFILL_ARBITER_CWF_EN
        if (d_req && d_we) begin
            w_start = {IDX_W{1'b0}};
        end else begin
            w_start = IDX_W'(w_sel_addr >> BYTE_W);
        end
`endif
    end

    // Next-state: D wins arbitration, bursts end on the ack of the last beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_next = DBURST;
                end else if (i_req) begin
                    w_next = IBURST;
                end else begin
                    w_next = IDLE;
                end
            end
            IBURST, DBURST: begin
                if (mem_ack && w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = r_state;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State plus request attributes captured at grant.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_base  <= {ADDR_W{1'b0}};
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= d_req ? OWN_D : OWN_I;
                r_base  <= w_sel_addr & ~OFF_MASK;
                r_we    <= d_req && d_we;
            end
        end
    end

    refill_beat_ctr #(
        .WORDS (LINE_WORDS),
        .W     (IDX_W)
    ) u_beat_ctr (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_grant),
        .i_start (w_start),
        .i_inc   (w_ack),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    // Read data and rvalid are combinational with mem_ack; everything idles at zero.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        i_rvalid  = 1'b0;
        i_idx     = {IDX_W{1'b0}};
        i_rdata   = {DATA_W{1'b0}};
        f_arrival = 1'b0;
        d_rvalid  = 1'b0;
        d_idx     = {IDX_W{1'b0}};
        d_rdata   = {DATA_W{1'b0}};
        m_arrival = 1'b0;
        case (r_state)
            IBURST: begin
                mem_req  = 1'b1;
                mem_addr = w_beat_addr;
                i_idx    = w_idx;
                i_rvalid = mem_ack;
                i_rdata  = mem_ack ? mem_rdata : {DATA_W{1'b0}};
            end
            DBURST: begin
                mem_req   = 1'b1;
                mem_addr  = w_beat_addr;
                mem_we    = r_we;
                mem_wdata = r_we ? d_wdata : {DATA_W{1'b0}};
                d_idx     = w_idx;
                d_rvalid  = mem_ack && !r_we;
                d_rdata   = (mem_ack && !r_we) ? mem_rdata : {DATA_W{1'b0}};
            end
            DONE: begin
                f_arrival = (r_owner == OWN_I);
                m_arrival = (r_owner == OWN_D);
            end
            IDLE:    mem_req = 1'b0;
            default: mem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Randomized bench for refill_arbiter with a transaction-level reference model and directed literal checks.
module tb_refill_arbiter;

    localparam int LW = 4;
`ifdef REFILL_ARBITER_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn, i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_req, mem_we, i_rvalid, f_arrival, d_rvalid, m_arrival;
    logic [31:0] mem_addr, mem_wdata, i_rdata, d_rdata;
    logic [1:0]  i_idx, d_idx;

    always #5 clk = ~clk;

    // D-cache writeback word source: a pattern keyed by the requested word index.
    function automatic logic [31:0] wpat(input logic [1:0] idx);
        return 32'hC0DE_0000 | ({30'd0, idx} * 32'h0000_0111);
    endfunction
    assign d_wdata = wpat(d_idx);

    refill_arbiter dut (
        .clk(clk), .rstn(rstn), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .i_rvalid(i_rvalid), .i_idx(i_idx), .i_rdata(i_rdata), .f_arrival(f_arrival),
        .d_rvalid(d_rvalid), .d_idx(d_idx), .d_rdata(d_rdata), .m_arrival(m_arrival)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    // Reference model: current owner (0 none, 1 I, 2 D), completion pending, beats done.
    int m_own = 0, m_done = 0, m_beat = 0, m_start = 0;
    logic [31:0] m_base = 32'd0;
    bit m_we = 1'b0;
    // Observation log.
    logic [31:0] q_addr[$];
    int q_idx[$], q_cyc[$];
    int f_cnt = 0, m_cnt = 0, irv_cnt = 0, drv_cnt = 0, we_cnt = 0, f_last = 0, m_last = 0;
    int ack_mode = 0, lat_cnt = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_own = 0; m_done = 0; m_beat = 0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_own == 0) begin
            if (d_req) begin
                m_own = 2; m_we = d_we; m_beat = 0;
                m_base = d_addr & ~32'(LW * 4 - 1);
                m_start = (CWF && !d_we) ? int'((d_addr >> 2) % 32'(LW)) : 0;
            end else if (i_req) begin
                m_own = 1; m_we = 1'b0; m_beat = 0;
                m_base = i_addr & ~32'(LW * 4 - 1);
                m_start = CWF ? int'((i_addr >> 2) % 32'(LW)) : 0;
            end
        end else if (mem_ack) begin
            m_beat++;
            if (m_beat == LW) begin
                m_done = m_own; m_own = 0;
            end
        end
    endtask

    task automatic drive();
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin
                if (mem_req) begin
                    lat_cnt++;
                    mem_ack = (lat_cnt >= 3);
                    if (lat_cnt >= 3) lat_cnt = 0;
                end else begin
                    mem_ack = 1'b0; lat_cnt = 0;
                end
            end
            default: mem_ack = 1'($urandom % 2);
        endcase
        mem_rdata = $urandom;
        if (f_arrival) i_req = 1'b0;
        if (m_arrival) d_req = 1'b0;
        if (rand_mode) begin
            if (!i_req && ($urandom % 6 == 0)) begin i_req = 1'b1; i_addr = $urandom; end
            else if (i_req && ($urandom % 16 == 0)) i_addr = $urandom;
            else if (i_req && ($urandom % 64 == 0)) i_req = 1'b0;
            if (!d_req && ($urandom % 8 == 0)) begin
                d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom % 2);
            end else if (d_req && ($urandom % 16 == 0)) begin
                d_addr = $urandom; d_we = 1'($urandom % 2);
            end
            rstn = ($urandom % 400 != 0);
        end
    endtask

    task automatic compare();
        int cur;
        cur = (m_start + m_beat) % LW;
        chk("mem_req", 32'(mem_req), 32'(m_own != 0));
        chk("f_arrival", 32'(f_arrival), 32'(m_done == 1));
        chk("m_arrival", 32'(m_arrival), 32'(m_done == 2));
        chk("i_rvalid", 32'(i_rvalid), 32'(m_own == 1 && mem_ack));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_own == 2 && !m_we && mem_ack));
        chk("mem_we", 32'(mem_we), 32'(m_own == 2 && m_we));
        if (m_own != 0) chk("mem_addr", mem_addr, m_base + 32'(cur * 4));
        if (m_own == 1) chk("i_idx", 32'(i_idx), 32'(cur));
        if (m_own == 2) chk("d_idx", 32'(d_idx), 32'(cur));
        if (m_own == 2 && m_we) chk("mem_wdata", mem_wdata, wpat(2'(cur)));
        if (m_own == 1 && mem_ack) chk("i_rdata", i_rdata, mem_rdata);
        if (m_own == 2 && !m_we && mem_ack) chk("d_rdata", d_rdata, mem_rdata);
        if (mem_req && mem_ack) begin
            q_addr.push_back(mem_addr);
            q_idx.push_back(i_rvalid ? int'(i_idx) : int'(d_idx));
            q_cyc.push_back(cyc);
        end
        if (f_arrival) begin f_cnt++; f_last = cyc; end
        if (m_arrival) begin m_cnt++; m_last = cyc; end
        if (i_rvalid) irv_cnt++;
        if (d_rvalid) drv_cnt++;
        if (mem_we && mem_ack) we_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        drive();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_arr(input bit is_d, input int budget, input string nm);
        int c0, k;
        c0 = is_d ? m_cnt : f_cnt;
        k = 0;
        while (((is_d ? m_cnt : f_cnt) == c0) && k < budget) begin step(); k++; end
        chk(nm, 32'((is_d ? m_cnt : f_cnt) - c0), 32'd1);
    endtask

    logic [31:0] e_addr[8];
    int e_idx[4];
    int a0, f0, m0, r0, w0, k;

    initial begin
        rstn = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; mem_rdata = 32'd0;
        repeat (3) step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_f_arrival", 32'(f_arrival), 32'd0);
        chk("rst_d_idx", 32'(d_idx), 32'd0);
        rstn = 1'b1;
        step();

        // Single I miss at 0x104, ack every cycle.
        a0 = q_addr.size();
        i_addr = 32'h104; i_req = 1'b1;
        wait_arr(1'b0, 20, "t1_timeout");
        if (CWF) begin
            e_addr[0] = 32'h104; e_addr[1] = 32'h108; e_addr[2] = 32'h10C; e_addr[3] = 32'h100;
            e_idx[0] = 1; e_idx[1] = 2; e_idx[2] = 3; e_idx[3] = 0;
        end else begin
            e_addr[0] = 32'h100; e_addr[1] = 32'h104; e_addr[2] = 32'h108; e_addr[3] = 32'h10C;
            e_idx[0] = 0; e_idx[1] = 1; e_idx[2] = 2; e_idx[3] = 3;
        end
        chk("t1_beats", 32'(q_addr.size() - a0), 32'd4);
        if (q_addr.size() >= a0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", q_addr[a0 + i], e_addr[i]);
                chk("t1_idx", 32'(q_idx[a0 + i]), 32'(e_idx[i]));
            end
            chk("t1_arrival_lat", 32'(f_last - q_cyc[a0 + 3]), 32'd1);
        end
        step(); step();

        // Simultaneous D refill and I miss: D first, one idle cycle, then I.
        a0 = q_addr.size(); m0 = m_cnt;
        i_addr = 32'h100; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        wait_arr(1'b0, 40, "t2_timeout");
        e_addr[0] = 32'h2000; e_addr[1] = 32'h2004; e_addr[2] = 32'h2008; e_addr[3] = 32'h200C;
        e_addr[4] = 32'h100;  e_addr[5] = 32'h104;  e_addr[6] = 32'h108;  e_addr[7] = 32'h10C;
        chk("t2_beats", 32'(q_addr.size() - a0), 32'd8);
        chk("t2_m_arrival", 32'(m_cnt - m0), 32'd1);
        chk("t2_order", 32'(f_last > m_last), 32'd1);
        if (q_addr.size() >= a0 + 8) begin
            for (int i = 0; i < 8; i++) chk("t2_addr", q_addr[a0 + i], e_addr[i]);
            chk("t2_gap", 32'(q_cyc[a0 + 4] - m_last), 32'd2);
        end
        step(); step();

        // D writeback from 0x3008 always starts at word 0.
        a0 = q_addr.size(); w0 = we_cnt; r0 = drv_cnt;
        d_addr = 32'h3008; d_we = 1'b1; d_req = 1'b1;
        wait_arr(1'b1, 20, "t3_timeout");
        chk("t3_we_beats", 32'(we_cnt - w0), 32'd4);
        chk("t3_no_rvalid", 32'(drv_cnt - r0), 32'd0);
        if (q_addr.size() >= a0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_addr", q_addr[a0 + i], 32'h3000 + 32'(i * 4));
                chk("t3_idx", 32'(q_idx[a0 + i]), 32'(i));
            end
        end
        d_we = 1'b0;
        step(); step();

        // Three-cycle ack latency per beat.
        ack_mode = 1; lat_cnt = 0;
        a0 = q_addr.size(); r0 = irv_cnt;
        i_addr = 32'h400; i_req = 1'b1;
        wait_arr(1'b0, 60, "t4_timeout");
        chk("t4_rvalid", 32'(irv_cnt - r0), 32'd4);
        if (q_addr.size() >= a0 + 4) begin
            for (int i = 0; i < 3; i++) chk("t4_spacing", 32'(q_cyc[a0 + i + 1] - q_cyc[a0 + i]), 32'd3);
            chk("t4_arrival_lat", 32'(f_last - q_cyc[a0 + 3]), 32'd1);
        end
        ack_mode = 0;
        step(); step();

        // Reset mid-burst: no arrival, then a fresh burst starts at beat 0.
        r0 = irv_cnt;
        i_addr = 32'h104; i_req = 1'b1;
        k = 0;
        while (irv_cnt < r0 + 2 && k < 20) begin step(); k++; end
        chk("t5_two_beats", 32'(irv_cnt - r0), 32'd2);
        rstn = 1'b0; i_req = 1'b0;
        step();
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        chk("t5_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("t5_i_idx", 32'(i_idx), 32'd0);
        chk("t5_f_arrival", 32'(f_arrival), 32'd0);
        rstn = 1'b1;
        f0 = f_cnt;
        repeat (4) step();
        chk("t5_no_arrival", 32'(f_cnt - f0), 32'd0);
        a0 = q_addr.size();
        i_addr = 32'h200; i_req = 1'b1;
        wait_arr(1'b0, 20, "t5_restart_timeout");
        if (q_addr.size() >= a0 + 1) begin
            chk("t5_restart_addr", q_addr[a0], 32'h200);
            chk("t5_restart_idx", 32'(q_idx[a0]), 32'd0);
        end
        step(); step();

        // i_req dropped after the first beat: burst still completes.
        a0 = q_addr.size(); r0 = irv_cnt;
        i_addr = 32'h500; i_req = 1'b1;
        k = 0;
        while (irv_cnt < r0 + 1 && k < 20) begin step(); k++; end
        i_req = 1'b0;
        wait_arr(1'b0, 20, "t6_timeout");
        chk("t6_beats", 32'(q_addr.size() - a0), 32'd4);
        step(); step();
        chk("t6_idle", 32'(mem_req), 32'd0);

        // Randomized traffic against the model.
        ack_mode = 2; rand_mode = 1'b1;
        repeat (4000) step();
        rand_mode = 1'b0; rstn = 1'b1; i_req = 1'b0; d_req = 1'b0; ack_mode = 0;
        repeat (30) step();
        chk("final_idle", 32'(mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
